rr_dec_arbiter: RTL and testbench
=================================

# rr_dec_arbiter

Round-robin scheduler that shares one resource among eight requesters and drives the one-hot select lines through a 3-to-8 decoder with enable. It sits ahead of the minterm/decoder datapath: it picks a requester index, holds it for the duration of the transaction, and advances priority fairly. The block enforces a bounded hold time so that no requester can monopolise the resource.

## Interface
- `MAX_HOLD`, default 15: maximum number of cycles a grant may be held before forced release. Legal range is 1..255.
- `clk  in  1`: single clock. All state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: global enable. Low blocks new grants and terminates the current grant.
- `req  in  8`: request vector. Bit i belongs to requester i.
- `done  in  1`: the current holder signals end of transaction. Sampled only in GRANT.
- `gnt  out  8`: one-hot grant, equal to the decoder output of `gnt_id` when enabled by `gnt_valid`. All zero when idle.
- `gnt_id  out  3`: index of the current holder. Holds its last value when idle.
- `gnt_valid  out  1`: high while a grant is active.
- `preempt  out  1`: one-cycle pulse when a grant is ended by the `MAX_HOLD` timeout.

## Operation
- **State machine** has two states, IDLE and GRANT. Reset state is IDLE.
- **IDLE**
  - If `en` is high and `req` is nonzero, select the first set bit searching upward from `ptr` with mod-8 wrap. Register its index into `gnt_id`, set `gnt_valid`, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT** releases the grant if any of the following holds (checked every cycle):
  - `done` is high, or
  - `req[gnt_id]` has dropped, or
  - `en` is low, or
  - `hold_cnt == MAX_HOLD-1`.
- **On release**
  - Clear `gnt_valid`, set `ptr <= gnt_id + 1` (3-bit wrap, so 7 goes to 0), and go to IDLE.
  - `preempt` pulses only when the timeout is the sole release cause (`done` low, request still high, `en` high).
  - Otherwise `hold_cnt` increments. Its width is 8 bits and it never wraps within a grant.
- **Arbitration gap:** IDLE always lasts at least one cycle between grants. This is a guaranteed bubble and is intended.
- **Pointer update:** `ptr` changes only on release, never while idle, so a requester that arrives late does not lose its turn.
- **Simultaneous events:**
  - `done` together with the timeout counts as a normal release; no `preempt`.
  - `en` low together with the timeout counts as a release; no `preempt`.
- **Grant output:** `gnt` is purely combinational from the registered `gnt_id`/`gnt_valid` through the decoder, so it is glitch-free relative to `clk`.
- **Reset mid-grant:** on the next edge the block returns to IDLE with `gnt=0`. `ptr` returns to 0 and the in-flight holder gets no release bookkeeping.

## Timing
- **Reset values:** `gnt=8'h00`, `gnt_id=3'd0`, `gnt_valid=0`, `preempt=0`, `ptr=0`, `hold_cnt=0`, state IDLE.
- **Grant latency:** a request sampled in IDLE at edge N produces `gnt`/`gnt_valid` after edge N (visible in cycle N+1).
- **Release latency:** a release cause sampled at edge M drops `gnt` after edge M. The earliest next grant is after edge M+1.
- **Maximum hold:** a grant lasts at most `MAX_HOLD` cycles with `gnt_valid` high. `preempt` is high in the first IDLE cycle after a timeout release.
- **Worst-case wait:** 7 × (`MAX_HOLD` + 1) cycles after a request is raised, given `en` stays high.

## Structure
- **Shared package (header):**
  - `NREQ = 8`
  - `IDW = 3`
  - state encodings `ST_IDLE = 1'b0`, `ST_GRANT = 1'b1`
- **Sub-module `dec3to8_en`:** a combinational 3-to-8 decoder with enable (inputs `w[2:0]`, `en`; output `y[7:0]`). It is instantiated once to produce `gnt` from `gnt_id` and `gnt_valid`.
- **Top level:** the priority search (rotate, find first, rotate back) lives in the top level as a combinational function.

## Test plan
- **Reset:** `rst` high for 2 cycles, with `req=8'hFF` and `en=1` -> `gnt=0`, `gnt_valid=0`, `preempt=0` throughout. After `rst` drops, `gnt=8'h01` one cycle later.
- **Rotation:** hold `req=8'hFF`, pulse `done` in the second grant cycle each time -> grant sequence `8'h01, 8'h02, 8'h04, … 8'h80, 8'h01`, with exactly one idle cycle between grants.
- **Skip and wrap:** `ptr` at 6 after requester 5 releases, then `req=8'b0000_0101` -> `gnt_id=0`, then `gnt_id=2`. Requesters 6 and 7 are skipped.
- **Timeout:** `MAX_HOLD=4`, `req[3]` held, `done=0` -> `gnt=8'h08` for exactly 4 cycles. `preempt` pulses one cycle, and the next grant starts at requester 4 or above.
- **Enable:** drop `en` mid-grant -> `gnt=0` next cycle with no `preempt`. While `en=0`, no grant for any `req`. Raising `en` again with `req=8'h10` -> `gnt=8'h10` one cycle later.
- **Request drop and simultaneous causes:**
  - holder drops `req[gnt_id]` -> release next edge.
  - `done` coincident with the final hold cycle -> release with `preempt=0`.

Source files
------------

// File: rtl/rr_dec_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin decoder arbiter.
package rr_dec_arbiter_pkg;

   localparam int NREQ = 8;
   localparam int IDW  = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/dec3to8_en.sv
// Combinational 3-to-8 one-hot decoder with active-high enable.
module dec3to8_en (
   input  logic [2:0] w,
   input  logic       en,
   output logic [7:0] y
);

   // Decode w to a one-hot line; all lines low when disabled.
   always_comb begin
      y = 8'h00;
      if (en) begin
         case (w)
            3'd0:    y = 8'h01;
            3'd1:    y = 8'h02;
            3'd2:    y = 8'h04;
            3'd3:    y = 8'h08;
            3'd4:    y = 8'h10;
            3'd5:    y = 8'h20;
            3'd6:    y = 8'h40;
            3'd7:    y = 8'h80;
            default: y = 8'h00;
         endcase
      end else begin
         y = 8'h00;
      end
   end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Eight-way round-robin arbiter with bounded hold time. The grant index is
// registered and decoded to one-hot select lines; priority advances past the
// holder on every release.
module rr_dec_arbiter
   import rr_dec_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_valid,
   output logic            preempt
);

   // Hold counter value on the last permitted grant cycle.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t           state_r,     state_s;
   logic [IDW-1:0]   gnt_id_r,    gnt_id_s;
   logic             gnt_valid_r, gnt_valid_s;
   logic [IDW-1:0]   ptr_r,       ptr_s;
   logic [7:0]       hold_cnt_r,  hold_cnt_s;
   logic             preempt_r,   preempt_s;

   logic [IDW-1:0]   pick_s;
   logic             rel_done_s;
   logic             rel_drop_s;
   logic             rel_en_s;
   logic             rel_tmo_s;

   // First set bit of r searching upward from p with mod-8 wrap:
   // rotate so p lands at bit 0, find first, then rotate the index back.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  p);
      logic [2*NREQ-1:0] dbl;
      logic [NREQ-1:0]   rot;
      logic [IDW-1:0]    off;
      logic              found;
      dbl   = {r, r} >> p;
      rot   = dbl[NREQ-1:0];
      off   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && rot[i]) begin
            off   = IDW'(i);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return off + p;
   endfunction

   assign pick_s     = rr_pick(req, ptr_r);
   assign rel_done_s = done;
   assign rel_drop_s = ~req[gnt_id_r];
   assign rel_en_s   = ~en;
   assign rel_tmo_s  = (hold_cnt_r == HOLD_LAST);

   // Next-state and next-register values for the IDLE/GRANT machine.
   always_comb begin
      state_s     = state_r;
      gnt_id_s    = gnt_id_r;
      gnt_valid_s = gnt_valid_r;
      ptr_s       = ptr_r;
      hold_cnt_s  = hold_cnt_r;
      preempt_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en && (req != 8'h00)) begin
               gnt_id_s    = pick_s;
               gnt_valid_s = 1'b1;
               hold_cnt_s  = 8'd0;
               state_s     = ST_GRANT;
            end else begin
               state_s     = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (rel_done_s || rel_drop_s || rel_en_s || rel_tmo_s) begin
               gnt_valid_s = 1'b0;
               ptr_s       = gnt_id_r + 3'd1;
               state_s     = ST_IDLE;
               // Preempt only when the timeout alone ended the grant.
               preempt_s   = rel_tmo_s & ~rel_done_s & ~rel_drop_s & ~rel_en_s;
            end else if (hold_cnt_r != 8'hFF) begin
               hold_cnt_s  = hold_cnt_r + 8'd1;
            end else begin
               hold_cnt_s  = hold_cnt_r;
            end
         end
         default: begin
            gnt_valid_s = 1'b0;
            state_s     = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         gnt_id_r    <= 3'd0;
         gnt_valid_r <= 1'b0;
         ptr_r       <= 3'd0;
         hold_cnt_r  <= 8'd0;
         preempt_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         gnt_id_r    <= gnt_id_s;
         gnt_valid_r <= gnt_valid_s;
         ptr_r       <= ptr_s;
         hold_cnt_r  <= hold_cnt_s;
         preempt_r   <= preempt_s;
      end
   end

   dec3to8_en u_dec (
      .w  (gnt_id_r),
      .en (gnt_valid_r),
      .y  (gnt)
   );

   assign gnt_id    = gnt_id_r;
   assign gnt_valid = gnt_valid_r;
   assign preempt   = preempt_r;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed self-checking bench for rr_dec_arbiter (MAX_HOLD = 4).
module tb_rr_dec_arbiter;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int passed = 0;
   int total  = 0;

   rr_dec_arbiter #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Check gnt, gnt_valid and preempt together.
   task automatic check_out(input string tag, input logic [7:0] g, input logic v, input logic p);
      check({tag, ".gnt"}, {24'd0, gnt}, {24'd0, g});
      check({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, v});
      check({tag, ".preempt"}, {31'd0, preempt}, {31'd0, p});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_g;
      rst  = 1'b1;
      en   = 1'b1;
      req  = 8'hFF;
      done = 1'b0;

      // Reset held for two cycles with requests pending.
      step();
      check_out("reset1", 8'h00, 1'b0, 1'b0);
      check("reset1.id", {29'd0, gnt_id}, 32'd0);
      step();
      check_out("reset2", 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_out("first_grant", 8'h01, 1'b1, 1'b0);
      check("first_grant.id", {29'd0, gnt_id}, 32'd0);

      // Rotation: done in second grant cycle, one idle cycle between grants.
      exp_g = 8'h01;
      for (int k = 1; k <= 8; k++) begin
         step();
         check_out("rot_hold", exp_g, 1'b1, 1'b0);
         done = 1'b1;
         step();
         done = 1'b0;
         check_out("rot_gap", 8'h00, 1'b0, 1'b0);
         step();
         exp_g = {exp_g[6:0], exp_g[7]};
         check_out("rot_next", exp_g, 1'b1, 1'b0);
      end

      // Skip and wrap: requester 5 releases by dropping its request.
      req = 8'h20;
      step();
      check_out("skip_drop0", 8'h00, 1'b0, 1'b0);
      step();
      check("skip_id5", {29'd0, gnt_id}, 32'd5);
      req = 8'b0000_0101;
      step();
      check_out("skip_drop5", 8'h00, 1'b0, 1'b0);
      step();
      check("wrap_id0", {29'd0, gnt_id}, 32'd0);
      check_out("wrap_g0", 8'h01, 1'b1, 1'b0);
      done = 1'b1;
      step();
      done = 1'b0;
      check_out("wrap_gap", 8'h00, 1'b0, 1'b0);
      step();
      check("wrap_id2", {29'd0, gnt_id}, 32'd2);

      // Timeout: requester 3 holds for exactly four cycles.
      req = 8'h08;
      step();
      check_out("tmo_gap", 8'h00, 1'b0, 1'b0);
      step();
      check_out("tmo_c1", 8'h08, 1'b1, 1'b0);
      step();
      check_out("tmo_c2", 8'h08, 1'b1, 1'b0);
      step();
      check_out("tmo_c3", 8'h08, 1'b1, 1'b0);
      step();
      check_out("tmo_c4", 8'h08, 1'b1, 1'b0);
      step();
      check_out("tmo_rel", 8'h00, 1'b0, 1'b1);
      req = 8'h18;
      step();
      check_out("tmo_next", 8'h10, 1'b1, 1'b0);
      check("tmo_next.id", {29'd0, gnt_id}, 32'd4);

      // Enable: dropping en ends the grant without preempt.
      en = 1'b0;
      step();
      check_out("en_drop", 8'h00, 1'b0, 1'b0);
      req = 8'hFF;
      step();
      check_out("en_block1", 8'h00, 1'b0, 1'b0);
      step();
      check_out("en_block2", 8'h00, 1'b0, 1'b0);
      en  = 1'b1;
      req = 8'h10;
      step();
      check_out("en_resume", 8'h10, 1'b1, 1'b0);

      // done coincident with the final hold cycle: no preempt.
      step();
      step();
      step();
      check_out("sim_last", 8'h10, 1'b1, 1'b0);
      done = 1'b1;
      step();
      done = 1'b0;
      check_out("sim_rel", 8'h00, 1'b0, 1'b0);
      step();
      check_out("sim_after", 8'h10, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
